// File: rtl/div_sched_pkg.sv
// Shared types for the divide reservation station and issue controller.
// Entry layout, tag constants, RV32M divide funct3 codes, issue FSM states.
package div_sched_pkg;

    // Operand/result width and ROB/CDB tag width shared by all entries
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    // Tag 0 means "no producer" and never matches a CDB broadcast
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic {
        IDLE,
        WAIT
    } issue_state_e;

    typedef struct packed {
        logic             valid;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  op1;
        logic             op1_rdy;
        logic [TAG_W-1:0] op1_tag;
        logic [XLEN-1:0]  op2;
        logic             op2_rdy;
        logic [TAG_W-1:0] op2_tag;
    } rs_entry_t;

    // Capture a CDB broadcast into any still-waiting operand of an entry
    function automatic rs_entry_t snoop(
        rs_entry_t        e,
        logic             cv,
        logic [TAG_W-1:0] ct,
        logic [XLEN-1:0]  cd
    );
        rs_entry_t r;
        r = e;
        if (e.valid && cv && (ct != TAG_NONE)) begin
            if (!e.op1_rdy && (e.op1_tag == ct)) begin
                r.op1     = cd;
                r.op1_rdy = 1'b1;
            end
            if (!e.op2_rdy && (e.op2_tag == ct)) begin
                r.op2     = cd;
                r.op2_rdy = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div_rs_entry.sv
// One reservation-station slot: holds an entry, takes a shifted or newly
// dispatched value, and snoops the CDB. Ports: clk/rst, i_flush, i_shift +
// i_shift_in (from slot above), i_load + i_load_data (dispatch), CDB,
// o_entry (current contents), o_ready (both operands present).
module div_rs_entry
    import div_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_shift,
    input  rs_entry_t        i_shift_in,
    input  logic             i_load,
    input  rs_entry_t        i_load_data,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [XLEN-1:0]  i_cdb_data,
    output rs_entry_t        o_entry,
    output logic             o_ready
);

    rs_entry_t r_entry;
    rs_entry_t w_src;

    // Dispatch lands after the shift, so a load overrides the shifted value
    always_comb begin
        w_src = r_entry;
        if (i_shift) begin
            w_src = i_shift_in;
        end
        if (i_load) begin
            w_src = i_load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
        end else if (i_flush) begin
            r_entry <= '0;
        end else begin
            r_entry <= snoop(w_src, i_cdb_valid, i_cdb_tag, i_cdb_data);
        end
    end

    assign o_entry = r_entry;
    assign o_ready = r_entry.valid & r_entry.op1_rdy & r_entry.op2_rdy;

endmodule

// File: rtl/div_issue_scheduler.sv
// Reservation station and issue controller for the shared multi-cycle divider.
// Ports: dispatch (disp_*), CDB snoop (cdb_*), divider handshake (div_busy,
// div_queue_en, held div_op1/op2/funct3/tag), flush, q_count occupancy.
module div_issue_scheduler
    import div_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [2:0]                 disp_funct3,
    input  logic [TAG_W-1:0]           disp_tag,
    input  logic [XLEN-1:0]            disp_op1,
    input  logic                       disp_op1_rdy,
    input  logic [TAG_W-1:0]           disp_op1_tag,
    input  logic [XLEN-1:0]            disp_op2,
    input  logic                       disp_op2_rdy,
    input  logic [TAG_W-1:0]           disp_op2_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    input  logic                       div_busy,
    output logic                       div_queue_en,
    output logic [XLEN-1:0]            div_op1,
    output logic [XLEN-1:0]            div_op2,
    output logic [2:0]                 div_funct3,
    output logic [TAG_W-1:0]           div_tag,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DIV_LAT + 1);

    issue_state_e r_state;
    issue_state_e w_state_nx;
    logic [LW-1:0] r_cnt;
    logic [LW-1:0] w_cnt_nx;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_cnt_post;

    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [2:0]       r_funct3;
    logic [TAG_W-1:0] r_tag;

    rs_entry_t        w_ent [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_shift;
    logic [DEPTH-1:0] w_load;
    rs_entry_t        w_load_data;
    rs_entry_t        w_sel_ent;
    logic [IW-1:0]    w_sel;
    logic             w_any;
    logic             w_issue;
    logic             w_disp;
    logic             w_disp_ready;

    // Ready is judged on pre-issue occupancy, so a full queue stays closed
    assign w_disp_ready = (r_count < CW'(DEPTH));
    assign w_disp       = disp_valid & w_disp_ready & ~flush;
    assign w_cnt_post   = r_count - CW'(w_issue);

    always_comb begin
        w_load_data         = '0;
        w_load_data.valid   = 1'b1;
        w_load_data.funct3  = disp_funct3;
        w_load_data.tag     = disp_tag;
        w_load_data.op1     = disp_op1;
        w_load_data.op1_rdy = disp_op1_rdy;
        w_load_data.op1_tag = disp_op1_tag;
        w_load_data.op2     = disp_op2;
        w_load_data.op2_rdy = disp_op2_rdy;
        w_load_data.op2_tag = disp_op2_tag;
    end

    // Oldest ready entry wins, even if an older one is still waiting
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
    end

    assign w_sel_ent = w_ent[w_sel];

    // Entries at and above the issued slot move down one place
    always_comb begin
        w_shift = '0;
        w_load  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_shift[i] = w_issue && (i >= int'(w_sel));
            w_load[i]  = w_disp && (w_cnt_post == CW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_entry_t w_up;
        if (g == DEPTH - 1) begin : g_top
            assign w_up = '0;
        end else begin : g_mid
            assign w_up = w_ent[g+1];
        end

        div_rs_entry u_ent (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (flush),
            .i_shift     (w_shift[g]),
            .i_shift_in  (w_up),
            .i_load      (w_load[g]),
            .i_load_data (w_load_data),
            .i_cdb_valid (cdb_valid),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_data  (cdb_data),
            .o_entry     (w_ent[g]),
            .o_ready     (w_rdy[g])
        );
    end

    // r_cnt counts cycles left until the divider result cycle (cnt==0)
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_issue    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any && !div_busy && !flush) begin
                    w_issue    = 1'b1;
                    w_state_nx = WAIT;
                    w_cnt_nx   = LW'(DIV_LAT - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt - LW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_cnt_post + CW'(w_disp);
        end
    end

    // The divider does not latch operands, so keep them until the next issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_funct3 <= '0;
            r_tag    <= '0;
        end else if (w_issue) begin
            r_op1    <= w_sel_ent.op1;
            r_op2    <= w_sel_ent.op2;
            r_funct3 <= w_sel_ent.funct3;
            r_tag    <= w_sel_ent.tag;
        end
    end

    assign div_queue_en = w_issue;
    assign div_op1      = w_issue ? w_sel_ent.op1 : r_op1;
    assign div_op2      = w_issue ? w_sel_ent.op2 : r_op2;
    assign div_funct3   = w_issue ? w_sel_ent.funct3 : r_funct3;
    assign div_tag      = w_issue ? w_sel_ent.tag : r_tag;
    assign disp_ready   = w_disp_ready;
    assign q_count      = r_count;

endmodule

// File: tb/tb_div_issue_scheduler.sv
// Randomized and directed bench for div_issue_scheduler against a queue-based
// reference model of the reservation station and divider occupancy.
module tb_div_issue_scheduler;
    import div_sched_pkg::*;

    localparam int DEPTH   = 4;
    localparam int DIV_LAT = 5;
    localparam int CW      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             disp_valid = 1'b0;
    logic             disp_ready;
    logic [2:0]       disp_funct3 = '0;
    logic [TAG_W-1:0] disp_tag = '0;
    logic [XLEN-1:0]  disp_op1 = '0;
    logic             disp_op1_rdy = 1'b0;
    logic [TAG_W-1:0] disp_op1_tag = '0;
    logic [XLEN-1:0]  disp_op2 = '0;
    logic             disp_op2_rdy = 1'b0;
    logic [TAG_W-1:0] disp_op2_tag = '0;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [XLEN-1:0]  cdb_data = '0;
    logic             div_busy = 1'b0;
    logic             div_queue_en;
    logic [XLEN-1:0]  div_op1;
    logic [XLEN-1:0]  div_op2;
    logic [2:0]       div_funct3;
    logic [TAG_W-1:0] div_tag;
    logic [CW-1:0]    q_count;

    always #5 clk = ~clk;

    div_issue_scheduler #(
        .DEPTH   (DEPTH),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_funct3  (disp_funct3),
        .disp_tag     (disp_tag),
        .disp_op1     (disp_op1),
        .disp_op1_rdy (disp_op1_rdy),
        .disp_op1_tag (disp_op1_tag),
        .disp_op2     (disp_op2),
        .disp_op2_rdy (disp_op2_rdy),
        .disp_op2_tag (disp_op2_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .div_busy     (div_busy),
        .div_queue_en (div_queue_en),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_funct3   (div_funct3),
        .div_tag      (div_tag),
        .q_count      (q_count)
    );

    typedef struct {
        logic [2:0]       f3;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  v1;
        bit               r1;
        logic [TAG_W-1:0] t1;
        logic [XLEN-1:0]  v2;
        bit               r2;
        logic [TAG_W-1:0] t2;
    } op_t;

    op_t              q[$];
    int               cyc = 0;
    int               res_cyc = -100;
    logic [XLEN-1:0]  h_op1 = '0;
    logic [XLEN-1:0]  h_op2 = '0;
    logic [2:0]       h_f3 = '0;
    logic [TAG_W-1:0] h_tag = '0;
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic op_t tsnoop(op_t m, bit cv, logic [TAG_W-1:0] ct,
                                   logic [XLEN-1:0] cd);
        op_t r;
        r = m;
        if (cv && ct != '0) begin
            if (!r.r1 && r.t1 == ct) begin
                r.v1 = cd;
                r.r1 = 1'b1;
            end
            if (!r.r2 && r.t2 == ct) begin
                r.v2 = cd;
                r.r2 = 1'b1;
            end
        end
        return r;
    endfunction

    // One clock cycle: drive, compare against the model, advance the model
    task automatic step(bit dv, logic [2:0] f3, logic [TAG_W-1:0] tg,
                        logic [XLEN-1:0] a, bit ar, logic [TAG_W-1:0] at,
                        logic [XLEN-1:0] b, bit br, logic [TAG_W-1:0] bt,
                        bit cv, logic [TAG_W-1:0] ct, logic [XLEN-1:0] cd,
                        bit busy, bit fl);
        op_t n;
        int  idx;
        bit  iss;
        bit  rdy_pre;
        disp_valid   = dv;
        disp_funct3  = f3;
        disp_tag     = tg;
        disp_op1     = a;
        disp_op1_rdy = ar;
        disp_op1_tag = at;
        disp_op2     = b;
        disp_op2_rdy = br;
        disp_op2_tag = bt;
        cdb_valid    = cv;
        cdb_tag      = ct;
        cdb_data     = cd;
        div_busy     = busy;
        flush        = fl;
        #1;
        idx = -1;
        foreach (q[i]) begin
            if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
        end
        rdy_pre = (q.size() < DEPTH);
        iss = (cyc > res_cyc) && (idx >= 0) && !busy && !fl;
        chk("q_count", 64'(q_count), 64'(q.size()));
        chk("disp_ready", 64'(disp_ready), 64'(rdy_pre));
        chk("div_queue_en", 64'(div_queue_en), 64'(iss));
        if (iss) begin
            h_op1   = q[idx].v1;
            h_op2   = q[idx].v2;
            h_f3    = q[idx].f3;
            h_tag   = q[idx].tag;
            res_cyc = cyc + DIV_LAT;
            q.delete(idx);
        end
        chk("div_op1", 64'(div_op1), 64'(h_op1));
        chk("div_op2", 64'(div_op2), 64'(h_op2));
        chk("div_funct3", 64'(div_funct3), 64'(h_f3));
        chk("div_tag", 64'(div_tag), 64'(h_tag));
        foreach (q[i]) q[i] = tsnoop(q[i], cv, ct, cd);
        if (dv && rdy_pre && !fl) begin
            n.f3  = f3;
            n.tag = tg;
            n.v1  = a;
            n.r1  = ar;
            n.t1  = at;
            n.v2  = b;
            n.r2  = br;
            n.t2  = bt;
            q.push_back(tsnoop(n, cv, ct, cd));
        end
        if (fl) q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n, bit busy);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, 0);
        end
    endtask

    task automatic disp(logic [2:0] f3, logic [TAG_W-1:0] tg,
                        logic [XLEN-1:0] a, bit ar, logic [TAG_W-1:0] at,
                        logic [XLEN-1:0] b, bit br, logic [TAG_W-1:0] bt,
                        bit busy);
        step(1, f3, tg, a, ar, at, b, br, bt, 0, 0, 0, busy, 0);
    endtask

    task automatic cdb(logic [TAG_W-1:0] ct, logic [XLEN-1:0] cd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ct, cd, 0, 0);
    endtask

    // Asserts reset between edges; outputs must clear without a clock
    task automatic do_reset();
        rst        = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        div_busy   = 1'b0;
        flush      = 1'b0;
        #1;
        chk("rst_q_count", 64'(q_count), 64'(0));
        chk("rst_disp_ready", 64'(disp_ready), 64'(1));
        chk("rst_queue_en", 64'(div_queue_en), 64'(0));
        chk("rst_op1", 64'(div_op1), 64'(0));
        chk("rst_op2", 64'(div_op2), 64'(0));
        chk("rst_funct3", 64'(div_funct3), 64'(0));
        chk("rst_tag", 64'(div_tag), 64'(0));
        q.delete();
        res_cyc = -100;
        h_op1 = '0;
        h_op2 = '0;
        h_f3  = '0;
        h_tag = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Ready op issues the cycle after dispatch, operands held
        disp(F3_DIV, 5, 100, 1, 0, 7, 1, 0, 0);
        idle(8, 0);

        // op2 waits on tag 9, broadcast two cycles later
        disp(F3_DIVU, 3, 20, 1, 0, 0, 0, 9, 0);
        idle(1, 0);
        cdb(9, 4);
        idle(8, 0);

        // Younger ready op bypasses an older waiting one
        disp(F3_REM, 1, 50, 0, 12, 3, 1, 0, 0);
        disp(F3_REMU, 2, 60, 1, 0, 9, 1, 0, 0);
        idle(2, 0);
        cdb(12, 77);
        idle(10, 0);

        // Fill under busy, fifth dispatch dropped, then drain
        for (int i = 0; i < 5; i++) begin
            disp(F3_DIV, TAG_W'(20 + i), XLEN'(1000 + i), 1, 0,
                 XLEN'(i + 1), 1, 0, 1);
        end
        idle(28, 0);

        // Operand captured from the CDB in the dispatch cycle
        step(1, F3_DIV, 7, 0, 0, 8, 11, 1, 0, 1, 8, 55, 0, 0);
        idle(8, 0);

        // Flush during WAIT with three queued, then reset mid-WAIT
        disp(F3_DIV, 30, 900, 1, 0, 30, 1, 0, 0);
        disp(F3_DIVU, 31, 1, 1, 0, 2, 1, 0, 0);
        disp(F3_REM, 32, 3, 1, 0, 4, 0, 40, 0);
        disp(F3_REMU, 33, 5, 1, 0, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4, 0);
        disp(F3_DIV, 34, 123, 1, 0, 45, 1, 0, 0);
        idle(3, 0);
        do_reset();

        for (int k = 0; k < 2000; k++) begin
            step(bit'($urandom_range(0, 1)),
                 3'($urandom_range(4, 7)),
                 TAG_W'($urandom_range(1, 63)),
                 XLEN'($urandom),
                 ($urandom_range(0, 9) < 6),
                 TAG_W'($urandom_range(1, 7)),
                 XLEN'($urandom),
                 ($urandom_range(0, 9) < 6),
                 TAG_W'($urandom_range(1, 7)),
                 ($urandom_range(0, 9) < 4),
                 TAG_W'($urandom_range(0, 7)),
                 XLEN'($urandom),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 99) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
